// File: rtl/mux_scan_sampler_pkg.sv
// Shared definitions for the 8:1 mux scan sampler: widths, FSM encoding and
// the scan-length normalisation helper.
package mux_scan_sampler_pkg;

   localparam int unsigned SelW  = 3;
   localparam int unsigned WordW = 8;
   localparam int unsigned CntW  = 4;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSettle = 2'd1,
      StSample = 2'd2,
      StOut    = 2'd3
   } scanState_e;

   // A request of 0 or more than a full word scans the whole word.
   function automatic logic [CntW-1:0] effCount(input logic [CntW-1:0] req);
      return ((req == '0) || (req > 4'd8)) ? 4'd8 : req;
   endfunction

endpackage

// File: rtl/mux_settle_timer.sv
// Load/run/done down-counter used to hold the mux select stable for the
// settle interval before each sample.
module mux_settle_timer #(
   parameter int unsigned Width = 4
) (
   input  logic             sysclk,
   input  logic             sysrst_n,
   input  logic             load,
   input  logic             run,
   input  logic [Width-1:0] loadVal,
   output logic             done
);

   logic [Width-1:0] cnt;

   // Load takes priority; otherwise count down to zero while running.
   always_ff @(posedge sysclk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= loadVal;
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/mux_scan_sampler.sv
// Drives the select of an 8:1 single-bit mux, waits for the path to settle,
// samples the mux output and assembles a run of bits into one word that is
// handed downstream over valid/ready.
module mux_scan_sampler
   import mux_scan_sampler_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic             sysclk,
   input  logic             sysrst_n,
   input  logic             start_i,
   input  logic [SelW-1:0]  first_i,
   input  logic [CntW-1:0]  count_i,
   input  logic             abort_i,
   output logic [SelW-1:0]  sel_o,
   input  logic             mux_i,
   output logic             busy_o,
   output logic [WordW-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i
);

   localparam bit HasSettle = (SETTLE != 0);
   localparam logic [CntW-1:0] SettleLoad = CntW'((SETTLE == 0) ? 0 : SETTLE - 1);
   // State entered after every select change.
   localparam scanState_e AfterSel = HasSettle ? StSettle : StSample;

   scanState_e       state;
   logic [CntW-1:0]  remaining;
   logic [WordW-1:0] shadow;
   logic [WordW-1:0] nextShadow;
   logic             lastBit;
   logic             timerLoad;
   logic             timerRun;
   logic             timerDone;

   // Shadow word with the current mux bit merged in at the selected position.
   always_comb begin
      nextShadow         = shadow;
      nextShadow[sel_o]  = mux_i;
      lastBit            = (remaining == 4'd1);
      timerRun           = (state == StSettle);
      timerLoad          = HasSettle && !abort_i &&
                           (((state == StIdle) && start_i) ||
                            ((state == StSample) && !lastBit));
   end

   mux_settle_timer #(
      .Width(CntW)
   ) uSettleTimer (
      .sysclk  (sysclk),
      .sysrst_n(sysrst_n),
      .load    (timerLoad),
      .run     (timerRun),
      .loadVal (SettleLoad),
      .done    (timerDone)
   );

   // Scan FSM with select, remaining, shadow and output registers; abort wins over all.
   always_ff @(posedge sysclk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         state     <= StIdle;
         sel_o     <= '0;
         remaining <= '0;
         shadow    <= '0;
         data_o    <= '0;
         valid_o   <= 1'b0;
      end else if (abort_i && (state != StIdle)) begin
         state   <= StIdle;
         valid_o <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (start_i && !abort_i) begin
                  sel_o     <= first_i;
                  remaining <= effCount(count_i);
                  shadow    <= '0;
                  state     <= AfterSel;
               end
            end
            StSettle: begin
               if (timerDone) begin
                  state <= StSample;
               end
            end
            StSample: begin
               shadow    <= nextShadow;
               remaining <= remaining - 4'd1;
               if (lastBit) begin
                  data_o  <= nextShadow;
                  valid_o <= 1'b1;
                  state   <= StOut;
               end else begin
                  sel_o <= sel_o + 3'd1;
                  state <= AfterSel;
               end
            end
            StOut: begin
               if (ready_i) begin
                  valid_o <= 1'b0;
                  state   <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign busy_o = (state != StIdle);

endmodule
